// File: rtl/tb_prefetch_server_pkg.sv
// Shared widths, request codes and FSM encoding for the traceback prefetch server.
// Optional feature macro: PF_STATS_EN (adds request / pad statistics counters).
package tb_prefetch_server_pkg;

    localparam int BP_WIDTH       = 2;
    localparam int POSITION_WIDTH = 10;
    localparam int PREFETCH_WIDTH = 5;
    localparam int BLOCK_SIZE     = 1 << PREFETCH_WIDTH;

    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        REQ_CUR  = 2'b01,
        REQ_PF   = 2'b10,
        REQ_BAD  = 2'b11
    } req_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && v != 16'hFFFF) return v + 16'd1;
        return v;
    endfunction

endpackage

// File: rtl/tb_prefetch_server_pf_addr_gen.sv
// Per-sequence address generator: signed down-counter from the window start,
// read enable only for non-negative indices, and a registered pad flag that
// substitutes the PAD code on the data returned one cycle later.
// Optional feature macro: PF_STATS_EN (exports the pad flag for counting).
module pf_addr_gen
    import tb_prefetch_server_pkg::*;
#(
    parameter int              POS_W = POSITION_WIDTH,
    parameter int              BP_W  = BP_WIDTH,
    parameter logic [BP_W-1:0] PAD   = '0
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             load,
    input  logic             issue,
    input  logic [POS_W-1:0] start,
    input  logic             vld,
    input  logic [BP_W-1:0]  rdata,
    output logic [POS_W-1:0] addr,
    output logic             rd,
    output logic [BP_W-1:0]  bp
`ifdef PF_STATS_EN
    ,
    output logic             pad
`endif
);

    // One extra bit so start-k below zero is visible as the MSB.
    logic [POS_W:0] cnt;
    logic           pad_q;
    logic           neg;

    assign neg  = cnt[POS_W];
    assign rd   = issue & ~neg;
    assign addr = rd ? cnt[POS_W-1:0] : '0;
    // RAM data lands exactly one cycle after rd, aligned with the registered valid.
    assign bp   = vld ? (pad_q ? PAD : rdata) : '0;
`ifdef PF_STATS_EN
    assign pad  = vld & pad_q;
`endif

    // Down-count per issued element; remember whether the issued index was padded.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt   <= '0;
            pad_q <= 1'b0;
        end else begin
            if (load)
                cnt <= {1'b0, start};
            else if (issue)
                cnt <= cnt - {{POS_W{1'b0}}, 1'b1};
            if (issue)
                pad_q <= neg;
        end
    end

endmodule

// File: rtl/tb_prefetch_server.sv
// Host-side responder to the traceback prefetch interface: on each request it
// reads one BLOCK of S and T bases (counting down from the window start) and
// streams them back with index, window select and last flag.
// Optional feature macro: PF_STATS_EN (req_cnt / pad_cnt outputs).
module tb_prefetch_server
    import tb_prefetch_server_pkg::*;
#(
    parameter int              BLOCK      = BLOCK_SIZE,
    parameter int              BP_W       = BP_WIDTH,
    parameter int              POS_W      = POSITION_WIDTH,
    parameter int              PREFETCH_W = PREFETCH_WIDTH,
    parameter logic [BP_W-1:0] PAD        = '0
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [1:0]            prefetch_request,
    input  logic [POS_W-1:0]      in_block_x_startpoint,
    input  logic [POS_W-1:0]      in_block_y_startpoint,
    input  logic [POS_W-1:0]      prefetch_x_startpoint,
    input  logic [POS_W-1:0]      prefetch_y_startpoint,
    input  logic                  done,
    output logic [POS_W-1:0]      s_addr,
    output logic [POS_W-1:0]      t_addr,
    output logic                  s_rd,
    output logic                  t_rd,
    input  logic [BP_W-1:0]       s_rdata,
    input  logic [BP_W-1:0]       t_rdata,
    output logic [BP_W-1:0]       pf_s,
    output logic [BP_W-1:0]       pf_t,
    output logic [PREFETCH_W-1:0] pf_idx,
    output logic                  pf_sel,
    output logic                  pf_valid,
    output logic                  pf_last,
    output logic                  busy,
    output logic                  err
`ifdef PF_STATS_EN
    ,
    output logic [15:0]           req_cnt,
    output logic [15:0]           pad_cnt
`endif
);

    localparam logic [PREFETCH_W-1:0] K_LAST = PREFETCH_W'(BLOCK - 1);

    state_e                state;
    logic [1:0]            req_q;
    logic [PREFETCH_W-1:0] kcnt;
    logic                  sel_q;

    logic                  pend_v;
    logic                  pend_sel;
    logic [POS_W-1:0]      pend_x;
    logic [POS_W-1:0]      pend_y;

    logic                  accept;
    logic                  acc_ok;
    logic                  req_sel;
    logic [POS_W-1:0]      req_x;
    logic [POS_W-1:0]      req_y;

    logic                  load;
    logic                  ld_sel;
    logic [POS_W-1:0]      ld_x;
    logic [POS_W-1:0]      ld_y;
    logic                  issue;

    // A held request level is accepted once: only a 00 -> non-00 transition counts.
    assign accept  = (prefetch_request != REQ_NONE) && (req_q == REQ_NONE) && !done;
    assign acc_ok  = accept && (prefetch_request != REQ_BAD);
    assign req_sel = (prefetch_request == REQ_PF);
    assign req_x   = req_sel ? prefetch_x_startpoint : in_block_x_startpoint;
    assign req_y   = req_sel ? prefetch_y_startpoint : in_block_y_startpoint;
    assign issue   = (state == ST_RUN);
    assign busy    = (state != ST_IDLE) | pend_v;

    // Window load source: pending slot wins in DRAIN, otherwise the live request.
    always_comb begin
        load   = 1'b0;
        ld_sel = req_sel;
        ld_x   = req_x;
        ld_y   = req_y;
        if (!done) begin
            case (state)
                ST_IDLE:  load = acc_ok;
                ST_DRAIN: begin
                    if (pend_v) begin
                        load   = 1'b1;
                        ld_sel = pend_sel;
                        ld_x   = pend_x;
                        ld_y   = pend_y;
                    end else begin
                        load = acc_ok;
                    end
                end
                default:  load = 1'b0;
            endcase
        end
    end

    // Service FSM with registered stream qualifiers and the 1-deep pending slot.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            req_q    <= REQ_NONE;
            kcnt     <= '0;
            sel_q    <= 1'b0;
            pend_v   <= 1'b0;
            pend_sel <= 1'b0;
            pend_x   <= '0;
            pend_y   <= '0;
            pf_valid <= 1'b0;
            pf_idx   <= '0;
            pf_sel   <= 1'b0;
            pf_last  <= 1'b0;
            err      <= 1'b0;
        end else begin
            req_q <= prefetch_request;
            if (accept && prefetch_request == REQ_BAD)
                err <= 1'b1;
            if (done) begin
                state    <= ST_IDLE;
                pend_v   <= 1'b0;
                pf_valid <= 1'b0;
                pf_last  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        pf_valid <= 1'b0;
                        pf_last  <= 1'b0;
                        if (load) begin
                            state <= ST_RUN;
                            kcnt  <= '0;
                            sel_q <= ld_sel;
                        end
                    end
                    ST_RUN: begin
                        // Qualifiers for element k appear with its RAM data next cycle.
                        pf_valid <= 1'b1;
                        pf_idx   <= K_LAST - kcnt;
                        pf_sel   <= sel_q;
                        pf_last  <= (kcnt == K_LAST);
                        kcnt     <= kcnt + 1'b1;
                        if (kcnt == K_LAST)
                            state <= ST_DRAIN;
                        if (acc_ok) begin
                            if (pend_v) begin
                                err <= 1'b1;
                            end else begin
                                pend_v   <= 1'b1;
                                pend_sel <= req_sel;
                                pend_x   <= req_x;
                                pend_y   <= req_y;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        pf_valid <= 1'b0;
                        pf_last  <= 1'b0;
                        kcnt     <= '0;
                        sel_q    <= ld_sel;
                        // A full pending slot is being consumed now; a new request still drops.
                        if (pend_v) begin
                            pend_v <= 1'b0;
                            state  <= ST_RUN;
                            if (acc_ok)
                                err <= 1'b1;
                        end else if (acc_ok) begin
                            state <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef PF_STATS_EN
    logic pad_s;
    logic pad_t;
`endif

    pf_addr_gen #(.POS_W(POS_W), .BP_W(BP_W), .PAD(PAD)) u_gen_s (
        .clk     (clk),
        .reset_i (reset_i),
        .load    (load),
        .issue   (issue),
        .start   (ld_x),
        .vld     (pf_valid),
        .rdata   (s_rdata),
        .addr    (s_addr),
        .rd      (s_rd),
        .bp      (pf_s)
`ifdef PF_STATS_EN
        ,
        .pad     (pad_s)
`endif
    );

    pf_addr_gen #(.POS_W(POS_W), .BP_W(BP_W), .PAD(PAD)) u_gen_t (
        .clk     (clk),
        .reset_i (reset_i),
        .load    (load),
        .issue   (issue),
        .start   (ld_y),
        .vld     (pf_valid),
        .rdata   (t_rdata),
        .addr    (t_addr),
        .rd      (t_rd),
        .bp      (pf_t)
`ifdef PF_STATS_EN
        ,
        .pad     (pad_t)
`endif
    );

`ifdef PF_STATS_EN
    // Requests that enter service (not 11, not dropped) and elements carrying any PAD base.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            req_cnt <= '0;
            pad_cnt <= '0;
        end else begin
            req_cnt <= sat_inc16(req_cnt, acc_ok && !pend_v);
            pad_cnt <= sat_inc16(pad_cnt, pad_s | pad_t);
        end
    end
`endif

endmodule

// File: tb/tb_tb_prefetch_server.sv
// Self-checking bench for tb_prefetch_server: directed scenarios plus a random
// request run, compared against a request-level schedule model and a RAM image.
module tb_tb_prefetch_server;

    localparam int POS_W = 10;
    localparam int BP_W  = 2;
    localparam int PW    = 5;
    localparam int BLK   = 32;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [1:0]       prefetch_request;
    logic [POS_W-1:0] in_block_x_startpoint, in_block_y_startpoint;
    logic [POS_W-1:0] prefetch_x_startpoint, prefetch_y_startpoint;
    logic             done;
    logic [POS_W-1:0] s_addr, t_addr;
    logic             s_rd, t_rd;
    logic [BP_W-1:0]  s_rdata, t_rdata;
    logic [BP_W-1:0]  pf_s, pf_t;
    logic [PW-1:0]    pf_idx;
    logic             pf_sel, pf_valid, pf_last, busy, err;
`ifdef PF_STATS_EN
    logic [15:0]      req_cnt, pad_cnt;
`endif

    always #5 clk = ~clk;

    tb_prefetch_server dut (
        .clk(clk), .reset_i(reset_i), .prefetch_request(prefetch_request),
        .in_block_x_startpoint(in_block_x_startpoint), .in_block_y_startpoint(in_block_y_startpoint),
        .prefetch_x_startpoint(prefetch_x_startpoint), .prefetch_y_startpoint(prefetch_y_startpoint),
        .done(done), .s_addr(s_addr), .t_addr(t_addr), .s_rd(s_rd), .t_rd(t_rd),
        .s_rdata(s_rdata), .t_rdata(t_rdata), .pf_s(pf_s), .pf_t(pf_t), .pf_idx(pf_idx),
        .pf_sel(pf_sel), .pf_valid(pf_valid), .pf_last(pf_last), .busy(busy), .err(err)
`ifdef PF_STATS_EN
        , .req_cnt(req_cnt), .pad_cnt(pad_cnt)
`endif
    );

    // Sequence RAM: 1-cycle read latency; junk when not read so missing PAD shows up.
    logic [1:0] s_mem [1024];
    logic [1:0] t_mem [1024];
    always @(posedge clk) begin
        s_rdata <= s_rd ? s_mem[s_addr] : 2'($urandom);
        t_rdata <= t_rd ? t_mem[t_addr] : 2'($urandom);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Issue record: [53:22] cycle, [21] s_rd, [20] t_rd, [19:10] s_addr, [9:0] t_addr
    // Data record:  [42:11] cycle, [10:9] s, [8:7] t, [6:2] idx, [1] sel, [0] last
    logic [63:0] exp_iss[$], obs_iss[$], exp_dat[$], obs_dat[$];
    int  st_acc[$], st_run[$], st_end[$];
    bit  m_err;
    logic [1:0] m_prev;
    bit  mon_en = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] iss_rec(input int c, input bit sr, input bit tr, input int sa, input int ta);
        logic [9:0] a = sr ? sa[9:0] : 10'd0;
        logic [9:0] b = tr ? ta[9:0] : 10'd0;
        return 64'({c, sr, tr, a, b});
    endfunction

    function automatic logic [63:0] dat_rec(input int c, input logic [1:0] s, input logic [1:0] t,
                                            input int idx, input logic sel, input logic last);
        return 64'({c, s, t, idx[4:0], sel, last});
    endfunction

    // Schedule one accepted request: a stream runs BLK cycles, then one DRAIN cycle.
    function automatic void schedule(input int n, input int x, input int y, input bit sel);
        int r;
        int l = st_run.size() - 1;
        if (l >= 0 && st_run[l] > n) begin
            m_err = 1;  // pending slot already taken
            return;
        end
        if (l >= 0 && n < st_end[l]) r = st_end[l] + 1;
        else r = n + 1;
        st_acc.push_back(n);
        st_run.push_back(r);
        st_end.push_back(r + BLK);
        for (int k = 0; k < BLK; k++) begin
            int sa = x - k;
            int ta = y - k;
            logic [1:0] sv = (sa >= 0) ? s_mem[sa] : 2'b00;
            logic [1:0] tv = (ta >= 0) ? t_mem[ta] : 2'b00;
            if (sa >= 0 || ta >= 0) exp_iss.push_back(iss_rec(r + k, sa >= 0, ta >= 0, sa, ta));
            exp_dat.push_back(dat_rec(r + 1 + k, sv, tv, BLK - 1 - k, sel, k == BLK - 1));
        end
    endfunction

    // done/reset sampled at cycle d: nothing of any stream survives past d.
    function automatic void truncate(input int d);
        while (st_run.size() > 0 && st_run[st_run.size()-1] > d) begin
            void'(st_acc.pop_back()); void'(st_run.pop_back()); void'(st_end.pop_back());
        end
        foreach (st_end[i]) if (st_end[i] > d) st_end[i] = d;
        while (exp_iss.size() > 0 && int'(exp_iss[exp_iss.size()-1][53:22]) > d) void'(exp_iss.pop_back());
        while (exp_dat.size() > 0 && int'(exp_dat[exp_dat.size()-1][42:11]) > d) void'(exp_dat.pop_back());
    endfunction

    function automatic bit busy_exp(input int c);
        foreach (st_acc[i]) if (st_acc[i] < c && c <= st_end[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_rd || t_rd) obs_iss.push_back(iss_rec(cyc, s_rd, t_rd, int'(s_addr), int'(t_addr)));
            if (pf_valid) obs_dat.push_back(dat_rec(cyc, pf_s, pf_t, int'(pf_idx), pf_sel, pf_last));
            check("busy", 64'(busy), 64'(busy_exp(cyc)));
        end
    end

    task automatic step(input logic [1:0] rq, input logic dn = 1'b0, input logic rs = 1'b0);
        prefetch_request = rq;
        done = dn;
        reset_i = rs;
        if (rs) begin
            truncate(cyc);
            m_err = 0;
            m_prev = 2'b00;
        end else begin
            if (dn) truncate(cyc);
            else if (rq != 2'b00 && m_prev == 2'b00) begin
                if (rq == 2'b11) m_err = 1;
                else if (rq == 2'b10) schedule(cyc, int'(prefetch_x_startpoint), int'(prefetch_y_startpoint), 1'b1);
                else schedule(cyc, int'(in_block_x_startpoint), int'(in_block_y_startpoint), 1'b0);
            end
            m_prev = rq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'b00);
    endtask

    task automatic do_reset();
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
    endtask

    task automatic set_win(input int x, input int y, input int px, input int py);
        in_block_x_startpoint = POS_W'(x);
        in_block_y_startpoint = POS_W'(y);
        prefetch_x_startpoint = POS_W'(px);
        prefetch_y_startpoint = POS_W'(py);
    endtask

    task automatic compare(input string tag);
        int ni = (obs_iss.size() < exp_iss.size()) ? obs_iss.size() : exp_iss.size();
        int nd = (obs_dat.size() < exp_dat.size()) ? obs_dat.size() : exp_dat.size();
        check({tag, "_iss_count"}, 64'(obs_iss.size()), 64'(exp_iss.size()));
        for (int i = 0; i < ni; i++) check({tag, "_iss"}, obs_iss[i], exp_iss[i]);
        check({tag, "_dat_count"}, 64'(obs_dat.size()), 64'(exp_dat.size()));
        for (int i = 0; i < nd; i++) check({tag, "_dat"}, obs_dat[i], exp_dat[i]);
        check({tag, "_err"}, 64'(err), 64'(m_err));
        obs_iss.delete(); exp_iss.delete(); obs_dat.delete(); exp_dat.delete();
    endtask

    initial begin
        foreach (s_mem[i]) begin
            s_mem[i] = 2'($urandom);
            t_mem[i] = 2'($urandom);
        end
        prefetch_request = 2'b00;
        done = 1'b0;
        reset_i = 1'b1;
        m_err = 0;
        m_prev = 2'b00;
        set_win(0, 0, 0, 0);
        do_reset();
        mon_en = 1;
        check("reset_outputs", 64'({pf_valid, pf_last, pf_sel, pf_idx, pf_s, pf_t, s_rd, t_rd, s_addr, t_addr}), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err), 64'd0);

        // Current-window refill, no padding.
        set_win(40, 35, 123, 456);
        step(2'b01); idle(40); compare("cur_40_35");

        // Prefetch-window refill with S and T padding.
        set_win(700, 800, 5, 0);
        step(2'b10); idle(40); compare("pf_5_0");

        // Second request queued mid-stream, served after DRAIN.
        set_win(40, 35, 900, 3);
        step(2'b01); idle(9); step(2'b10); idle(80); compare("back_to_back");

        // Three requests in one stream: third dropped.
        set_win(200, 31, 17, 600);
        step(2'b01); idle(3); step(2'b10); idle(3); step(2'b01); idle(100); compare("overflow");

        // Illegal code, then a held level counts once.
        do_reset();
        step(2'b11); idle(5);
        check("illegal_err", 64'(err), 64'd1);
        set_win(10, 64, 0, 0);
        repeat (5) step(2'b01);
        idle(45); compare("held_level");

        // done at element 12 with a request pending.
        do_reset();
        set_win(300, 20, 8, 9);
        step(2'b01); idle(4); step(2'b10); idle(7);
        step(2'b00, 1'b1);
        check("done_valid", 64'(pf_valid), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        check("done_rd", 64'({s_rd, t_rd}), 64'd0);
        idle(60); compare("done_abort");

        // reset_i at element 20 with a request pending.
        do_reset();
        set_win(25, 500, 40, 2);
        step(2'b01); idle(4); step(2'b10); idle(15);
        step(2'b00, 1'b0, 1'b1);
        check("rst_valid", 64'(pf_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        idle(60); compare("reset_abort");

        // Random request traffic.
        do_reset();
        begin
            logic [1:0] rq = 2'b00;
            for (int i = 0; i < 1500; i++) begin
                int r;
                set_win($urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023),
                        $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023),
                        $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023),
                        $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023));
                if ($urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 19);
                    if (r < 12) rq = 2'b00;
                    else if (r < 16) rq = 2'b01;
                    else if (r < 19) rq = 2'b10;
                    else rq = 2'b11;
                end
                step(rq, $urandom_range(0, 199) == 0);
            end
        end
        idle(80); compare("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
